serial_frame_rx: RTL and testbench

//  Parametrised receiver for the two-wire serialClock/serialData link: bit recovery by oversampling, SFD hunt,

---
 rtl/serial_frame_rx.sv | 181 ++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Receiver for the two-wire serialClock/serialData link. Each serialClock
//   high pulse that lasts READ_CYCLES synchronised samples yields one bit.
//   Bits are hunted for the start-frame delimiter, then WIDTH payload bits
//   (MSB first) and an optional even-parity bit are captured. The finished
//   frame goes into a one-entry valid/ready buffer. Frames that fail are
//   reported on single-cycle error pulses and are never delivered.
// Ports
//   clock        system clock, posedge
//   reset        synchronous, active-high
//   serialClock  link clock line (asynchronous)
//   serialData   link data line (asynchronous)
//   out_data     payload of the held frame
//   out_valid    held frame available
//   out_ready    consumer accepts (transfer on out_valid && out_ready)
//   parity_err   pulse: frame dropped, parity mismatch
//   timeout_err  pulse: frame aborted, bit gap too long
//   overflow     pulse: good frame dropped, buffer still occupied
module serial_frame_rx #(
  parameter int          WIDTH          = 16,
  parameter int          SFD_BITS       = 64,
  parameter logic [63:0] SFD            = 64'haaaaaaaaaaaaaaab,
  parameter int          PARITY_EN      = 0,
  parameter int          READ_CYCLES    = 6,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serialClock,
  input  logic             serialData,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             timeout_err,
  output logic             overflow
);

  localparam int HCW = $clog2(READ_CYCLES + 1);
  localparam int GCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

  state_t state, state_nxt;

  logic [1:0]          sclk_sync, sdat_sync;
  logic                sclk, sdat;
  logic [HCW-1:0]      high_cnt;
  logic                armed, strobe;
  logic [SFD_BITS-1:0] sfd_reg, sfd_shift;
  logic                sfd_hit;
  logic [WIDTH-1:0]    shift_buf, payload_nxt, frame_word;
  logic [IW-1:0]       idx;
  logic                last_bit;
  logic [GCW-1:0]      gap_cnt;
  logic                gap_expire;
  logic                done, perr, terr, load;

  assign sclk = sclk_sync[1];
  assign sdat = sdat_sync[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync <= '0;
      sdat_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], serialClock};
      sdat_sync <= {sdat_sync[0], serialData};
    end
  end

  // Bit recovery: one strobe per high pulse, on the READ_CYCLES-th high
  // sample; disarmed until serialClock returns low.
  assign strobe = sclk && armed && (high_cnt == HCW'(READ_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || !sclk) begin
      high_cnt <= '0;
      armed    <= 1'b1;
    end else if (armed) begin
      high_cnt <= high_cnt + 1'b1;
      if (strobe) armed <= 1'b0;
    end
  end

  // Width cast keeps the low SFD_BITS bits, so SFD_BITS == 1 needs no special case.
  assign sfd_shift  = SFD_BITS'({sfd_reg, sdat});
  assign sfd_hit    = (sfd_shift == SFD[SFD_BITS-1:0]);
  assign last_bit   = (idx == '0);
  assign gap_expire = !strobe && (gap_cnt == GCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    payload_nxt      = shift_buf;
    payload_nxt[idx] = sdat;
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (strobe && sfd_hit) state_nxt = DATA;
      DATA:    if (strobe && last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : HUNT;
               else if (gap_expire)    state_nxt = HUNT;
      PARITY:  if (strobe || gap_expire) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // FSM: frame-completion events
  always_comb begin
    done       = 1'b0;
    perr       = 1'b0;
    terr       = 1'b0;
    frame_word = payload_nxt;
    case (state)
      DATA: begin
        if (strobe && last_bit && PARITY_EN == 0) done = 1'b1;
        else if (gap_expire)                      terr = 1'b1;
      end
      PARITY: begin
        frame_word = shift_buf;
        if (strobe) begin
          if (^{shift_buf, sdat}) perr = 1'b1;
          else                    done = 1'b1;
        end else if (gap_expire) begin
          terr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A completing frame may replace one being accepted in the same cycle.
  assign load = done && (!out_valid || out_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
      sfd_reg     <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      shift_buf   <= '0;
    end else begin
      parity_err  <= perr;
      timeout_err <= terr;
      overflow    <= done && !load;

      if (load) begin
        out_data  <= frame_word;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Held at zero outside HUNT so every return to HUNT starts from scratch.
      if (state != HUNT)  sfd_reg <= '0;
      else if (strobe)    sfd_reg <= sfd_hit ? '0 : sfd_shift;

      // Cleared in HUNT and on each bit; leaves DATA/PARITY before it can wrap.
      if (state == HUNT || strobe) gap_cnt <= '0;
      else                         gap_cnt <= gap_cnt + 1'b1;

      if (state == HUNT)              idx <= IW'(WIDTH - 1);
      else if (state == DATA && strobe) idx <= idx - 1'b1;

      if (state == DATA && strobe) shift_buf <= payload_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx. Two instances watch the same link:
// dut (64-bit SFD, no parity) and dut_p (8-bit SFD 8'hAB, even parity).
// Every frame is sent with the 64-bit delimiter and a trailing parity bit;
// dut_p locks on the last eight delimiter bits, dut treats the parity bit as
// stray HUNT input. A frame-level model predicts each instance's events.
module tb_serial_frame_rx;

  localparam int          RC   = 6;
  localparam int          TO   = 64;
  localparam logic [63:0] SFD64 = 64'haaaaaaaaaaaaaaab;
  localparam int XFER = 0, OVF = 1, PERR = 2, TERR = 3;

  logic clock = 1'b0;
  logic reset, serialClock, serialData, out_ready;
  logic [15:0] d0, d1;
  logic v0, v1, pe0, pe1, te0, te1, of0, of1;

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  serial_frame_rx #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .serialClock(serialClock), .serialData(serialData),
    .out_data(d0), .out_valid(v0), .out_ready(out_ready),
    .parity_err(pe0), .timeout_err(te0), .overflow(of0));

  serial_frame_rx #(.WIDTH(16), .SFD_BITS(8), .SFD(64'hAB), .PARITY_EN(1)) dut_p (
    .clock(clock), .reset(reset), .serialClock(serialClock), .serialData(serialData),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready),
    .parity_err(pe1), .timeout_err(te1), .overflow(of1));

  typedef struct { int kind; logic [15:0] data; } evt_t;
  evt_t q0[$], q1[$];
  int n_chk = 0, n_fail = 0;

  // frame-level model of the one-entry buffer
  logic        m_held [2];
  logic [15:0] m_word [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input int kind, input logic [15:0] d);
    if (i == 0) q0.push_back(evt_t'{kind, d});
    else        q1.push_back(evt_t'{kind, d});
  endtask

  task automatic observe(input int i, input int kind, input logic [15:0] d);
    evt_t e;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      n_chk++; n_fail++;
      $display("FAIL dut%0d unexpected event: got kind %0d data %h expected none", i, kind, d);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d event kind", i), kind, e.kind);
    if (kind == XFER) chk($sformatf("dut%0d out_data", i), d, e.data);
  endtask

  // monitor
  logic pv0 = 0, pv1 = 0, pr = 0;
  logic [15:0] pd0 = 0, pd1 = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (v0 && out_ready) observe(0, XFER, d0);
      if (of0) observe(0, OVF, 16'h0);
      if (pe0) observe(0, PERR, 16'h0);
      if (te0) observe(0, TERR, 16'h0);
      if (v1 && out_ready) observe(1, XFER, d1);
      if (of1) observe(1, OVF, 16'h0);
      if (pe1) observe(1, PERR, 16'h0);
      if (te1) observe(1, TERR, 16'h0);
      if (pv0 && !pr && v0) chk("dut0 held data stable", d0, pd0);
      if (pv1 && !pr && v1) chk("dut1 held data stable", d1, pd1);
    end
    pv0 <= v0; pv1 <= v1; pd0 <= d0; pd1 <= d1; pr <= out_ready;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic tx_bit(input logic b, input int hi, input int lo);
    serialData  = b;
    serialClock = 1'b1;
    repeat (hi) tick();
    serialClock = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic set_ready(input logic r);
    if (r) begin
      for (int i = 0; i < 2; i++)
        if (m_held[i]) begin push(i, XFER, m_word[i]); m_held[i] = 1'b0; end
    end
    out_ready = r;
    tick();
  endtask

  task automatic predict(input int i, input logic [15:0] w, input logic bad);
    if (bad)                        push(i, PERR, 16'h0);
    else if (out_ready)             push(i, XFER, w);
    else if (m_held[i])             push(i, OVF, 16'h0);
    else begin m_held[i] = 1'b1; m_word[i] = w; end
  endtask

  task automatic send_sfd();
    for (int i = 63; i >= 0; i--) tx_bit(SFD64[i], 8, 8);
  endtask

  // glitch: a 5-cycle pulse with inverted data after payload bit 10, and a
  // 20-cycle high on payload bit 4
  task automatic send_frame(input logic [15:0] w, input logic bad, input bit glitch);
    predict(0, w, 1'b0);
    predict(1, w, bad);
    send_sfd();
    for (int i = 15; i >= 0; i--) begin
      tx_bit(w[i], (glitch && i == 4) ? 20 : 8, 8);
      if (glitch && i == 10) tx_bit(~w[9], RC - 1, 8);
    end
    tx_bit((^w) ^ bad, 8, 8);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " dut0 out_valid"}, v0, 0);   chk({tag, " dut0 out_data"}, d0, 0);
    chk({tag, " dut0 errors"}, {pe0, te0, of0}, 0);
    chk({tag, " dut1 out_valid"}, v1, 0);   chk({tag, " dut1 out_data"}, d1, 0);
    chk({tag, " dut1 errors"}, {pe1, te1, of1}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int unsigned c;
    bit f0, f1;
    m_held[0] = 0; m_held[1] = 0;
    reset = 1; serialClock = 0; serialData = 0; out_ready = 0;
    repeat (3) tick();
    reset = 0;
    @(negedge clock);
    check_idle("reset");

    // single frame, consumer ready
    set_ready(1);
    send_frame(16'hBEEF, 0, 0);

    // back-to-back with consumer stalled, then drain
    set_ready(0);
    send_frame(16'h1234, 0, 0);
    send_frame(16'h5678, 0, 0);
    repeat (5) tick();
    set_ready(1);

    // parity good / bad
    send_frame(16'h0001, 0, 0);
    send_frame(16'h0001, 1, 0);
    @(negedge clock);
    chk("dut1 valid after parity error", v1, 0);

    // timeout after 5 payload bits
    w = 16'hC0DE;
    push(0, TERR, 0); push(1, TERR, 0);
    send_sfd();
    for (int i = 15; i > 11; i--) tx_bit(w[i], 8, 8);
    c = cyc;
    tx_bit(w[11], 8, 8);
    f0 = 0; f1 = 0;
    for (int k = 0; k < 200 && !(f0 && f1); k++) begin
      @(negedge clock);
      if (te0 && !f0) begin f0 = 1; chk("dut0 timeout latency", cyc - c, 2 + RC + TO); end
      if (te1 && !f1) begin f1 = 1; chk("dut1 timeout latency", cyc - c, 2 + RC + TO); end
    end
    chk("timeout pulses seen", {f0, f1}, 2'b11);
    tick();
    send_frame(16'h9ABC, 0, 0);

    // glitch rejection and long high pulse
    send_frame(16'h3C5A, 0, 1);

    // reset mid-payload with a frame held
    set_ready(0);
    send_frame(16'hC3C3, 0, 0);
    send_sfd();
    for (int i = 0; i < 8; i++) tx_bit(i[0], 8, 8);
    reset = 1;
    tick();
    reset = 0;
    m_held[0] = 0; m_held[1] = 0;
    @(negedge clock);
    check_idle("mid-frame reset");
    chk("dut0 scoreboard empty at reset", q0.size(), 0);
    chk("dut1 scoreboard empty at reset", q1.size(), 0);
    tick();
    set_ready(1);
    send_frame(16'hA5A5, 0, 0);

    // randomized frames
    for (int n = 0; n < 8; n++) begin
      set_ready(1'($urandom_range(0, 1)));
      send_frame(16'($urandom), ($urandom_range(0, 3) == 0), 0);
    end
    set_ready(1);
    repeat (20) tick();
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
